// File: rtl/ram_arbiter.sv
// Two-requester arbiter for the shared 64 KB RAM: CPU-first priority with a
// streak limit that guarantees the diagnostics engine a slot.
module ram_arbiter #(
  parameter int ACCESS_CYCLES  = 2,
  parameter int MAX_CPU_STREAK = 4
) (
  input  logic        fpga_clk,
  input  logic        fpga_reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  input  logic        diag_req,
  input  logic        diag_we,
  input  logic [15:0] diag_addr,
  input  logic [7:0]  diag_wdata,
  output logic        diag_ack,
  output logic [7:0]  diag_rdata,
  output logic [15:0] ram_address,
  output logic [7:0]  ram_data_out,
  input  logic [7:0]  ram_data_in,
  output logic        ram_cs,
  output logic        ram_we,
  output logic        owner
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } state_t;

  localparam logic [3:0] CNT_LOAD   = 4'(ACCESS_CYCLES - 1);
  localparam logic [3:0] STREAK_MAX = 4'(MAX_CPU_STREAK);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  r_streak;
  logic        r_we;
  logic [15:0] r_addr;
  logic [7:0]  r_wdata;
  logic        r_owner;
  logic [7:0]  r_cpu_rdata;
  logic [7:0]  r_diag_rdata;

  logic        w_grant_cpu;
  logic        w_grant_diag;
  logic        w_last_cycle;
  logic        w_diag_forced;

  assign w_diag_forced = diag_req && (r_streak == STREAK_MAX);
  assign w_last_cycle  = (r_state == ST_ACCESS) && (r_cnt == 4'd0);

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_cpu  = 1'b0;
    w_grant_diag = 1'b0;
    ram_cs       = 1'b0;
    ram_we       = 1'b0;
    cpu_ack      = 1'b0;
    diag_ack     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cpu_req && !w_diag_forced) begin
          w_grant_cpu = 1'b1;
        end else if (diag_req) begin
          w_grant_diag = 1'b1;
        end
        if (w_grant_cpu || w_grant_diag) begin
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        ram_cs = 1'b1;
        ram_we = r_we;
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        cpu_ack     = ~r_owner;
        diag_ack    = r_owner;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign ram_address  = r_addr;
  assign ram_data_out = r_wdata;
  assign owner        = r_owner;
  assign cpu_rdata    = r_cpu_rdata;
  assign diag_rdata   = r_diag_rdata;

  // NOTE: state is updated with non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge fpga_clk) begin
    if (fpga_reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 4'd0;
      r_streak     <= 4'd0;
      r_we         <= 1'b0;
      r_addr       <= 16'd0;
      r_wdata      <= 8'd0;
      r_owner      <= 1'b0;
      r_cpu_rdata  <= 8'd0;
      r_diag_rdata <= 8'd0;
    end else begin
      r_state <= w_state_nxt;

      if (w_grant_cpu) begin
        r_we    <= cpu_we;
        r_addr  <= cpu_addr;
        r_wdata <= cpu_wdata;
        r_owner <= 1'b0;
        r_cnt   <= CNT_LOAD;
      end else if (w_grant_diag) begin
        r_we    <= diag_we;
        r_addr  <= diag_addr;
        r_wdata <= diag_wdata;
        r_owner <= 1'b1;
        r_cnt   <= CNT_LOAD;
      end else if (r_state == ST_ACCESS && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end

      // The streak only counts CPU wins that actually kept diag waiting.
      if (r_state == ST_IDLE) begin
        if (w_grant_diag || !diag_req) begin
          r_streak <= 4'd0;
        end else if (w_grant_cpu && r_streak != STREAK_MAX) begin
          r_streak <= r_streak + 4'd1;
        end
      end

      if (w_last_cycle && !r_we) begin
        if (r_owner) begin
          r_diag_rdata <= ram_data_in;
        end else begin
          r_cpu_rdata <= ram_data_in;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 64 KB RAM attached.
module tb_ram_arbiter;

  logic        fpga_clk;
  logic        fpga_reset;
  logic        cpu_req, cpu_we, cpu_ack;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        diag_req, diag_we, diag_ack;
  logic [15:0] diag_addr;
  logic [7:0]  diag_wdata, diag_rdata;
  logic [15:0] ram_address;
  logic [7:0]  ram_data_out, ram_data_in;
  logic        ram_cs, ram_we, owner;

  logic [7:0]  mem [0:65535];
  int          n_pass = 0;
  int          n_fail = 0;
  int          n_total = 0;

  ram_arbiter #(.ACCESS_CYCLES(2), .MAX_CPU_STREAK(4)) dut (
    .fpga_clk    (fpga_clk),
    .fpga_reset  (fpga_reset),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_ack     (cpu_ack),
    .cpu_rdata   (cpu_rdata),
    .diag_req    (diag_req),
    .diag_we     (diag_we),
    .diag_addr   (diag_addr),
    .diag_wdata  (diag_wdata),
    .diag_ack    (diag_ack),
    .diag_rdata  (diag_rdata),
    .ram_address (ram_address),
    .ram_data_out(ram_data_out),
    .ram_data_in (ram_data_in),
    .ram_cs      (ram_cs),
    .ram_we      (ram_we),
    .owner       (owner)
  );

  initial fpga_clk = 1'b0;
  always #5 fpga_clk = ~fpga_clk;

  // RAM model: preloaded while the bench holds reset, written on cs & we.
  always @(posedge fpga_clk) begin
    if (fpga_reset) begin
      mem[16'h1234] <= 8'h3C;
      mem[16'h0010] <= 8'h11;
      mem[16'h0020] <= 8'h22;
    end else if (ram_cs && ram_we) begin
      mem[ram_address] <= ram_data_out;
    end
  end
  assign ram_data_in = mem[ram_address];

  task automatic tick;
    @(posedge fpga_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One complete access by a single requester, checked cycle by cycle.
  task automatic access(input string tag, input logic is_diag, input logic we,
                        input logic [15:0] addr, input logic [7:0] wdata,
                        input logic [7:0] exp_rdata);
    if (is_diag) begin
      diag_req = 1'b1; diag_we = we; diag_addr = addr; diag_wdata = wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end
    tick;
    check({tag, " a1 cs"}, 16'(ram_cs), 16'd1);
    check({tag, " a1 we"}, 16'(ram_we), 16'(we));
    check({tag, " a1 addr"}, ram_address, addr);
    check({tag, " a1 dout"}, 16'(ram_data_out), 16'(wdata));
    check({tag, " a1 owner"}, 16'(owner), 16'(is_diag));
    check({tag, " a1 acks"}, 16'({cpu_ack, diag_ack}), 16'd0);
    tick;
    check({tag, " a2 cs"}, 16'(ram_cs), 16'd1);
    check({tag, " a2 we"}, 16'(ram_we), 16'(we));
    tick;
    check({tag, " done cs"}, 16'({ram_cs, ram_we}), 16'd0);
    check({tag, " done cpu_ack"}, 16'(cpu_ack), 16'(!is_diag));
    check({tag, " done diag_ack"}, 16'(diag_ack), 16'(is_diag));
    check({tag, " done rdata"}, 16'(is_diag ? diag_rdata : cpu_rdata), 16'(exp_rdata));
    cpu_req  = 1'b0;
    diag_req = 1'b0;
    tick;
    check({tag, " idle acks"}, 16'({cpu_ack, diag_ack}), 16'd0);
    check({tag, " idle cs"}, 16'(ram_cs), 16'd0);
  endtask

  initial begin
    fpga_reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'd0; cpu_wdata = 8'd0;
    diag_req = 1'b0; diag_we = 1'b0; diag_addr = 16'd0; diag_wdata = 8'd0;
    tick;
    tick;
    check("reset cs/we", 16'({ram_cs, ram_we}), 16'd0);
    check("reset acks", 16'({cpu_ack, diag_ack}), 16'd0);
    check("reset addr", ram_address, 16'd0);
    check("reset dout/owner", 16'({ram_data_out, owner}), 16'd0);
    check("reset rdata", {cpu_rdata, diag_rdata}, 16'd0);
    fpga_reset = 1'b0;
    tick;

    access("cpu rd 1234", 1'b0, 1'b0, 16'h1234, 8'h00, 8'h3C);
    access("diag wr ffff", 1'b1, 1'b1, 16'hFFFF, 8'hA5, 8'h00);
    access("cpu rd ffff", 1'b0, 1'b0, 16'hFFFF, 8'h00, 8'hA5);

    // Simultaneous requests: CPU first, diag on the next grant.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
    diag_req = 1'b1; diag_we = 1'b0; diag_addr = 16'hFFFF;
    tick;
    check("simul first owner", 16'(owner), 16'd0);
    check("simul first cs", 16'(ram_cs), 16'd1);
    tick;
    tick;
    check("simul cpu_ack", 16'({cpu_ack, diag_ack}), 16'b10);
    check("simul cpu_rdata", 16'(cpu_rdata), 16'h3C);
    cpu_req = 1'b0;
    tick;
    check("simul idle gap", 16'(ram_cs), 16'd0);
    tick;
    check("simul second owner", 16'(owner), 16'd1);
    check("simul second addr", ram_address, 16'hFFFF);
    tick;
    tick;
    check("simul diag_ack", 16'({cpu_ack, diag_ack}), 16'b01);
    check("simul diag_rdata", 16'(diag_rdata), 16'hA5);
    diag_req = 1'b0;
    tick;

    // Starvation guard: both requests held for ten grants.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    diag_req = 1'b1; diag_we = 1'b0; diag_addr = 16'h0020;
    for (int g = 0; g < 10; g++) begin
      logic exp_diag;
      exp_diag = (g == 4) || (g == 9);
      tick;
      check($sformatf("streak g%0d owner", g), 16'(owner), 16'(exp_diag));
      check($sformatf("streak g%0d cs", g), 16'(ram_cs), 16'd1);
      tick;
      tick;
      check($sformatf("streak g%0d acks", g), 16'({cpu_ack, diag_ack}),
            exp_diag ? 16'b01 : 16'b10);
      check($sformatf("streak g%0d rdata", g),
            16'(exp_diag ? diag_rdata : cpu_rdata), exp_diag ? 16'h22 : 16'h11);
      tick;
      check($sformatf("streak g%0d ack pulse", g), 16'({cpu_ack, diag_ack}), 16'd0);
    end
    cpu_req = 1'b0;
    diag_req = 1'b0;
    tick;

    access("cpu wr keeps rdata", 1'b0, 1'b1, 16'h0030, 8'h77, 8'h11);

    // Reset during the second ACCESS cycle of a CPU write.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0100; cpu_wdata = 8'h5A;
    tick;
    check("rst a1 cs/we", 16'({ram_cs, ram_we}), 16'b11);
    tick;
    check("rst a2 cs/we", 16'({ram_cs, ram_we}), 16'b11);
    fpga_reset = 1'b1;
    cpu_req = 1'b0;
    tick;
    check("rst edge cs/we", 16'({ram_cs, ram_we}), 16'd0);
    check("rst edge acks", 16'({cpu_ack, diag_ack}), 16'd0);
    tick;
    check("rst held acks", 16'({cpu_ack, diag_ack}), 16'd0);
    fpga_reset = 1'b0;
    tick;
    tick;
    check("post-rst ctl", 16'({ram_cs, ram_we, cpu_ack, diag_ack, owner}), 16'd0);
    check("post-rst addr", ram_address, 16'd0);
    check("post-rst dout", 16'(ram_data_out), 16'd0);
    check("post-rst rdata", {cpu_rdata, diag_rdata}, 16'd0);

    // Requester drops its request right after the grant edge.
    diag_req = 1'b1; diag_we = 1'b0; diag_addr = 16'h0020;
    tick;
    check("drop a1 cs", 16'(ram_cs), 16'd1);
    diag_req = 1'b0;
    tick;
    check("drop a2 cs", 16'(ram_cs), 16'd1);
    tick;
    check("drop ack", 16'({cpu_ack, diag_ack}), 16'b01);
    check("drop rdata", 16'(diag_rdata), 16'h22);
    tick;
    check("drop idle1", 16'({ram_cs, cpu_ack, diag_ack}), 16'd0);
    tick;
    check("drop idle2", 16'({ram_cs, cpu_ack, diag_ack}), 16'd0);
    tick;
    check("drop idle3", 16'({ram_cs, cpu_ack, diag_ack}), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single 64 KB on-board RAM between two requesters: the CPU bus front end and the diagnostics engine that reads and writes the memory map over SPI.
- Serialises accesses and applies fixed CPU-first priority, with a streak limit so diagnostic traffic cannot starve.
- Drives the RAM control lines (address, write data, cs, we) and returns read data and a one-cycle ack to whichever requester owned the access.

Parameters:
- ACCESS_CYCLES, 2: cycles ram_cs is held per access; legal range 1..15.
- MAX_CPU_STREAK, 4: consecutive CPU grants allowed while diag_req is pending before diag is forced a slot; legal range 1..15.

Ports:
- fpga_clk  in  1  system clock; all logic on rising edge.
- fpga_reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; valid with cpu_req.
- cpu_addr  in  16  CPU access address.
- cpu_wdata  in  8  CPU write data.
- cpu_ack  out  1  one-cycle pulse: CPU access complete.
- cpu_rdata  out  8  CPU read data; valid while cpu_ack is high, then held.
- diag_req, diag_we, diag_addr[15:0], diag_wdata[7:0]  in  as CPU  diagnostics requester.
- diag_ack, diag_rdata[7:0]  out  as CPU  diagnostics completion.
- ram_address  out  16  RAM address.
- ram_data_out  out  8  RAM write data.
- ram_data_in  in  8  RAM read data.
- ram_cs  out  1  RAM chip select, active high.
- ram_we  out  1  RAM write enable, active high.
- owner  out  1  0 = CPU, 1 = diag; owner of the current or last access.

Behaviour:
- Clocking and reset:
  - One clock (fpga_clk); synchronous active-high reset (fpga_reset).
  - While reset is high, all outputs are forced to 0 and state goes to IDLE; streak counter = 0.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - Sample both req lines each cycle.
  - Only CPU requesting: grant CPU. Only diag requesting: grant diag.
  - Both requesting: grant diag if streak == MAX_CPU_STREAK, otherwise grant CPU.
  - On a grant, latch we/addr/wdata of the winner, set owner, go to ACCESS, load the access counter with ACCESS_CYCLES-1.
- Streak counter:
  - Increments on a CPU grant when diag_req was also high; saturates at MAX_CPU_STREAK.
  - Clears on a diag grant, and on any IDLE cycle with diag_req low.
- ACCESS:
  - ram_cs = 1; ram_address and ram_data_out = latched values.
  - ram_we = latched we, held for all ACCESS cycles.
  - Count down. At count 0, capture ram_data_in into the owner's rdata register (reads only) and go to DONE.
- DONE:
  - ram_cs = ram_we = 0; address and data hold their values.
  - Owner's ack = 1 for exactly this cycle. Next state: IDLE.
- Latency: req first seen high at IDLE edge T → ram_cs high cycles T+1..T+ACCESS_CYCLES → ack high in cycle T+ACCESS_CYCLES+1 → IDLE at T+ACCESS_CYCLES+2.
  - Back-to-back throughput is one access per ACCESS_CYCLES+2 cycles.
- Handshake:
  - A requester holds req and its inputs stable until its ack.
  - It must deassert req, or present the next request, on the edge ending the ack cycle.
  - Changes to inputs after the grant edge do not affect the access in flight.
  - A req dropped mid-access is still completed and acked.
- rdata holds its last captured value; a write access leaves rdata unchanged.
- Only one ack is ever high in a given cycle; the non-owner requester's ack stays 0.
- Reset mid-access: ram_cs and ram_we drop at the reset edge, no ack is issued, and the latched request is discarded.

Test Plan:
- CPU read: ACCESS_CYCLES=2, RAM holds 0x3C at 0x1234, cpu_req read 0x1234 → ram_cs high 2 cycles with address 0x1234, then cpu_ack high 1 cycle with cpu_rdata=0x3C; diag_ack stays 0.
- Diag write: diag writes 0xA5 to 0xFFFF (top-of-map wrap address) → ram_we and ram_cs high 2 cycles, ram_data_out=0xA5; diag_ack pulses once; a subsequent CPU read of 0xFFFF returns 0xA5.
- Simultaneous first requests: cpu_req and diag_req rise in the same cycle → CPU is granted first (owner=0), diag is served by the next grant.
- Starvation guard: MAX_CPU_STREAK=4, cpu_req and diag_req held continuously → grant order CPU,CPU,CPU,CPU,diag,CPU,CPU,CPU,CPU,diag; every ack is a single-cycle pulse.
- Reset mid-access: fpga_reset asserted in the 2nd ACCESS cycle of a CPU write → ram_cs=ram_we=0 and no ack at the next edge; after release with no reqs, the block idles with all outputs 0.
- Requester drops req after the grant edge: the access still completes, ack pulses, and the block returns to IDLE with no second access.
